esp_ctrl_seq: RTL

Parametrised power-up and reset sequencer for the ESP8266 Wi-Fi module. It drives CH_PD (enable), RST (active-low) and GPIO0 (boot-mode strap) in the correct order. It holds each phase for a programmable number of cycles and reports busy/ready to the rest of the system. It sits between the system control logic and the module pins, alongside the UART path.

---
 rtl/esp_ctrl_seq_if.sv | 22 ++
 rtl/esp_ctrl_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/esp_ctrl_seq_if.sv
// Control/pin bundle between system logic and the ESP8266 power/reset sequencer.
// master = system side driving requests, slave = the sequencer.
interface esp_ctrl_seq_if;
  logic pwr_en;
  logic rst;
  logic boot_mode;
  logic mod_en;
  logic mod_rst;
  logic mod_gpio0;
  logic busy;
  logic ready;

  modport master (
    output pwr_en, rst, boot_mode,
    input  mod_en, mod_rst, mod_gpio0, busy, ready
  );

  modport slave (
    input  pwr_en, rst, boot_mode,
    output mod_en, mod_rst, mod_gpio0, busy, ready
  );
endinterface

// File: rtl/esp_ctrl_seq.sv
// ESP8266 power-up/reset sequencer: OFF -> RESET (mod_rst low) -> BOOT -> READY.
// Pin outputs are registered decodes of the next state, so no input reaches a pin combinationally.
module esp_ctrl_seq #(
  parameter int RST_CYCLES  = 15,
  parameter int BOOT_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int RETRIGGER   = 0
) (
  input logic          clk,
  input logic          sys_rst,
  esp_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {S_OFF, S_RESET, S_BOOT, S_READY} state_t;

  typedef struct packed {
    logic en;
    logic rst_n;
    logic gpio0;
    logic busy;
    logic ready;
  } pins_t;

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES - 1);
  localparam logic             RETRIG_EN = (RETRIGGER != 0);
  localparam pins_t            PINS_OFF  = '{en: 1'b0, rst_n: 1'b0, gpio0: 1'b1, busy: 1'b0, ready: 1'b0};

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             boot_q, boot_d;
  pins_t            pins_q;
  logic             retrig;

  // GPIO0 carries the latched strap only while the module is held in / leaving reset.
  function automatic pins_t decode(state_t s, logic bq);
    pins_t p;
    p = PINS_OFF;
    unique case (s)
      S_OFF:   p = PINS_OFF;
      S_RESET: p = '{en: 1'b1, rst_n: 1'b0, gpio0: ~bq, busy: 1'b1, ready: 1'b0};
      S_BOOT:  p = '{en: 1'b1, rst_n: 1'b1, gpio0: ~bq, busy: 1'b1, ready: 1'b0};
      S_READY: p = '{en: 1'b1, rst_n: 1'b1, gpio0: 1'b1, busy: 1'b0, ready: 1'b1};
      default: p = PINS_OFF;
    endcase
    return p;
  endfunction

  assign retrig = RETRIG_EN && bus.rst && ((state == S_RESET) || (state == S_BOOT));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    boot_d  = boot_q;
    if (!bus.pwr_en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_d = S_RESET;
          cnt_d   = RST_LOAD;
          boot_d  = bus.boot_mode;
        end
        S_RESET: begin
          if (retrig) begin
            cnt_d  = RST_LOAD;
            boot_d = bus.boot_mode;
          end else if (cnt == '0) begin
            state_d = S_BOOT;
            cnt_d   = BOOT_LOAD;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        S_BOOT: begin
          // A retrigger on the final BOOT cycle still wins over the READY exit.
          if (retrig) begin
            state_d = S_RESET;
            cnt_d   = RST_LOAD;
            boot_d  = bus.boot_mode;
          end else if (cnt == '0) begin
            state_d = S_READY;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        S_READY: begin
          if (bus.rst) begin
            state_d = S_RESET;
            cnt_d   = RST_LOAD;
            boot_d  = bus.boot_mode;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state  <= S_OFF;
      cnt    <= '0;
      boot_q <= 1'b0;
      pins_q <= PINS_OFF;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      boot_q <= boot_d;
      pins_q <= decode(state_d, boot_d);
    end
  end

  assign bus.mod_en    = pins_q.en;
  assign bus.mod_rst   = pins_q.rst_n;
  assign bus.mod_gpio0 = pins_q.gpio0;
  assign bus.busy      = pins_q.busy;
  assign bus.ready     = pins_q.ready;

endmodule
